// File: rtl/lab2_proc_decode_imm_sched.sv
// Decode-stage instruction buffer with immediate-type classification.
// Instructions are classified once at enqueue and then held in a small
// circular FIFO. The head entry drives D combinationally. Dequeuing an
// illegal opcode parks the block in HALT until reset.
`timescale 1ns/1ps
module lab2_proc_decode_imm_sched #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_val,
    output logic        in_rdy,
    input  logic [31:0] in_inst,
    output logic        out_val,
    input  logic        out_rdy,
    output logic [31:0] out_inst,
    output logic [2:0]  out_imm_type,
    output logic        out_imm_used,
    output logic        out_illegal,
    input  logic        squash,
    output logic [3:0]  occupancy,
    output logic        halted
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {RUN, HALT} state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [2:0]  imm_type;
        logic        imm_used;
        logic        illegal;
    } entry_t;

    state_t        state;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [3:0]    occ;
    entry_t        mem [DEPTH];
    entry_t        in_ent;
    entry_t        head_ent;
    logic          enq;
    logic          deq;

    // Wrap a pointer at DEPTH-1 so non-power-of-two depths stay in range.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Classify the incoming opcode; the result is stored alongside the entry.
    always_comb begin
        in_ent          = '0;
        in_ent.inst     = in_inst;
        case (in_inst[6:0])
            7'b0000011, 7'b0010011,
            7'b1100111, 7'b1110011: begin in_ent.imm_type = 3'd0; in_ent.imm_used = 1'b1; end
            7'b0100011:             begin in_ent.imm_type = 3'd1; in_ent.imm_used = 1'b1; end
            7'b1100011:             begin in_ent.imm_type = 3'd2; in_ent.imm_used = 1'b1; end
            7'b0110111, 7'b0010111: begin in_ent.imm_type = 3'd3; in_ent.imm_used = 1'b1; end
            7'b1101111:             begin in_ent.imm_type = 3'd4; in_ent.imm_used = 1'b1; end
            7'b0110011:             begin in_ent.imm_type = 3'd0; in_ent.imm_used = 1'b0; end
            default:                begin in_ent.imm_type = 3'd0; in_ent.illegal  = 1'b1; end
        endcase
    end

    // Handshakes depend only on registered state, so out_rdy never reaches in_rdy.
    assign in_rdy       = (state == RUN) && (occ < 4'(DEPTH));
    assign out_val      = (state == RUN) && (occ != 4'd0);
    assign enq          = in_val && in_rdy;
    assign deq          = out_val && out_rdy;
    assign head_ent     = mem[head];
    assign out_inst     = head_ent.inst;
    assign out_imm_type = head_ent.imm_type;
    assign out_imm_used = head_ent.imm_used;
    assign out_illegal  = head_ent.illegal;
    assign occupancy    = occ;
    assign halted       = (state == HALT);

    // Entry storage needs no reset; only occupancy decides what is live.
    always_ff @(posedge clk) begin
        if (enq && !squash)
            mem[tail] <= in_ent;
    end

    // Pointers, occupancy and RUN/HALT state; squash outranks everything but reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            head  <= '0;
            tail  <= '0;
            occ   <= '0;
        end else if (squash) begin
            // A same-cycle dequeue was already sampled by D; just drop the rest.
            occ  <= '0;
            head <= tail;
        end else begin
            if (deq && out_illegal)
                state <= HALT;
            case ({enq, deq})
                2'b10: begin
                    tail <= ptr_next(tail);
                    occ  <= occ + 4'd1;
                end
                2'b01: begin
                    head <= ptr_next(head);
                    occ  <= occ - 4'd1;
                end
                2'b11: begin
                    tail <= ptr_next(tail);
                    head <= ptr_next(head);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lab2_proc_decode_imm_sched.sv
// Scoreboard bench for the decode instruction buffer: the stimulus process
// queues expected head entries on enqueue, a negedge monitor pops them on
// every dequeue, and state/occupancy checks run inline with the stimulus.
`timescale 1ns/1ps
module tb_lab2_proc_decode_imm_sched;

    logic        clk;
    logic        reset;
    logic        in_val;
    logic        in_rdy;
    logic [31:0] in_inst;
    logic        out_val;
    logic        out_rdy;
    logic [31:0] out_inst;
    logic [2:0]  out_imm_type;
    logic        out_imm_used;
    logic        out_illegal;
    logic        squash;
    logic [3:0]  occupancy;
    logic        halted;

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  ty;
        logic        used;
        logic        ill;
    } exp_t;

    exp_t q[$];
    exp_t nx;
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    lab2_proc_decode_imm_sched #(.DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .in_val(in_val), .in_rdy(in_rdy), .in_inst(in_inst),
        .out_val(out_val), .out_rdy(out_rdy), .out_inst(out_inst),
        .out_imm_type(out_imm_type), .out_imm_used(out_imm_used),
        .out_illegal(out_illegal), .squash(squash),
        .occupancy(occupancy), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_enq(input logic [31:0] i, input logic [2:0] t, input logic u, input logic il);
        in_val  = 1'b1;
        in_inst = i;
        nx      = '{i, t, u, il};
    endtask

    // Record the enqueue that will fire at the coming edge, then advance.
    task automatic tick();
        if (in_val && in_rdy && !squash)
            q.push_back(nx);
        @(posedge clk);
        #1;
    endtask

    // Monitor: each dequeue must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset) begin
            total++;
            if (occupancy > 4'd2) begin
                bad++;
                $display("FAIL occ_bound: got %0d want <=2", occupancy);
            end
            if (out_val && out_rdy) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL deq_unexpected: got inst 0x%08h want none", out_inst);
                end else begin
                    mon_e = q.pop_front();
                    chk("deq_inst", out_inst, mon_e.inst);
                    chk("deq_type", 32'(out_imm_type), 32'(mon_e.ty));
                    chk("deq_used", 32'(out_imm_used), 32'(mon_e.used));
                    chk("deq_illegal", 32'(out_illegal), 32'(mon_e.ill));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] cls_i [6] = '{32'h00500093, 32'h0020A023, 32'h00000063,
                               32'h000010B7, 32'h0000006F, 32'h002081B3};
    logic [2:0]  cls_t [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    logic        cls_u [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        reset = 1'b1; in_val = 1'b0; in_inst = '0; out_rdy = 1'b0; squash = 1'b0;
        nx = '{32'h0, 3'd0, 1'b0, 1'b0};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_out_val", 32'(out_val), 32'd0);
        chk("rst_in_rdy", 32'(in_rdy), 32'd1);
        chk("rst_halted", 32'(halted), 32'd0);
        reset = 1'b0;
        tick();

        // Classification stream with D always ready.
        out_rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive_enq(cls_i[k], cls_t[k], cls_u[k], 1'b0);
            tick();
            if (k == 0) begin
                chk("first_val", 32'(out_val), 32'd1);
                chk("first_inst", out_inst, 32'h00500093);
            end
        end
        in_val = 1'b0;
        tick();
        chk("cls_drain_occ", 32'(occupancy), 32'd0);

        // Fill, partial drain, wrap.
        out_rdy = 1'b0;
        drive_enq(32'h00100013, 3'd0, 1'b1, 1'b0); tick();
        drive_enq(32'h00000037, 3'd3, 1'b1, 1'b0); tick();
        in_val = 1'b0;
        chk("full_in_rdy", 32'(in_rdy), 32'd0);
        chk("full_occ", 32'(occupancy), 32'd2);
        out_rdy = 1'b1; tick(); out_rdy = 1'b0;
        chk("after_deq_in_rdy", 32'(in_rdy), 32'd1);
        chk("after_deq_occ", 32'(occupancy), 32'd1);
        drive_enq(32'h00000023, 3'd1, 1'b0 | 1'b1, 1'b0); tick();
        in_val = 1'b0;
        chk("wrap_occ", 32'(occupancy), 32'd2);
        chk("wrap_head", out_inst, 32'h00000037);
        out_rdy = 1'b1; tick(); tick(); out_rdy = 1'b0;
        chk("wrap_drain_occ", 32'(occupancy), 32'd0);

        // Simultaneous enqueue and dequeue at occupancy 1.
        drive_enq(32'h00000017, 3'd3, 1'b1, 1'b0); tick();
        drive_enq(32'h00000067, 3'd0, 1'b1, 1'b0); out_rdy = 1'b1; tick();
        chk("simul_occ", 32'(occupancy), 32'd1);
        chk("simul_inst", out_inst, 32'h00000067);
        in_val = 1'b0; tick(); out_rdy = 1'b0;
        chk("simul_drain_occ", 32'(occupancy), 32'd0);

        // Squash from full, then squash racing an accepted enqueue.
        drive_enq(32'h00000073, 3'd0, 1'b1, 1'b0); tick();
        drive_enq(32'h00000003, 3'd0, 1'b1, 1'b0); tick();
        chk("sq_pre_occ", 32'(occupancy), 32'd2);
        drive_enq(32'h00000033, 3'd0, 1'b0, 1'b0); squash = 1'b1; tick();
        q.delete(); squash = 1'b0; in_val = 1'b0;
        chk("sq_occ", 32'(occupancy), 32'd0);
        chk("sq_out_val", 32'(out_val), 32'd0);
        drive_enq(32'h00000073, 3'd0, 1'b1, 1'b0); tick();
        drive_enq(32'h00000033, 3'd0, 1'b0, 1'b0); squash = 1'b1; tick();
        q.delete(); squash = 1'b0; in_val = 1'b0;
        tick();
        chk("sq_drop_occ", 32'(occupancy), 32'd0);
        chk("sq_drop_val", 32'(out_val), 32'd0);

        // Illegal opcode halts after it is dequeued.
        drive_enq(32'hFFFFFFFF, 3'd0, 1'b0, 1'b1); tick();
        drive_enq(32'h00500093, 3'd0, 1'b1, 1'b0); tick();
        in_val = 1'b0;
        chk("ill_flag", 32'(out_illegal), 32'd1);
        out_rdy = 1'b1; tick();
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_out_val", 32'(out_val), 32'd0);
        chk("halt_in_rdy", 32'(in_rdy), 32'd0);
        chk("halt_occ", 32'(occupancy), 32'd1);
        out_rdy = 1'b0;
        drive_enq(32'h00000013, 3'd0, 1'b1, 1'b0); squash = 1'b1; tick();
        q.delete(); squash = 1'b0; in_val = 1'b0;
        chk("halt_sq_halted", 32'(halted), 32'd1);
        chk("halt_sq_occ", 32'(occupancy), 32'd0);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("unhalt_halted", 32'(halted), 32'd0);
        chk("unhalt_occ", 32'(occupancy), 32'd0);
        chk("unhalt_in_rdy", 32'(in_rdy), 32'd1);

        // Asynchronous reset between edges.
        drive_enq(32'h00100013, 3'd0, 1'b1, 1'b0); tick();
        drive_enq(32'h00200013, 3'd0, 1'b1, 1'b0); tick();
        in_val = 1'b0;
        chk("ar_pre_occ", 32'(occupancy), 32'd2);
        #1 reset = 1'b1;
        #1;
        chk("ar_out_val", 32'(out_val), 32'd0);
        chk("ar_occ", 32'(occupancy), 32'd0);
        #1 reset = 1'b0;
        q.delete();
        tick();
        chk("ar_post_occ", 32'(occupancy), 32'd0);
        chk("ar_post_in_rdy", 32'(in_rdy), 32'd1);

        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lab2_proc_decode_imm_sched.md
Name: lab2_proc_decode_imm_sched

Overview:
- Decode-stage instruction buffer and immediate scheduler for the lab2 pipelined processor.
- Accepts fetched instructions over a val/rdy interface and classifies each opcode at enqueue.
- Stores the immediate-type select (0=I, 1=S, 2=B, 3=U, 4=J) that drives the D-stage immediate generator.
- Presents instructions in order to D, handles squash from X, and halts permanently after issuing an illegal opcode.

Parameters:
- DEPTH, 2, number of buffer entries; legal range 1..8; pointers wrap modulo DEPTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- in_val  input  1  F stage has a valid instruction
- in_rdy  output  1  buffer can accept an instruction
- in_inst  input  32  fetched instruction
- out_val  output  1  head entry valid to D
- out_rdy  input  1  D stage accepts the head entry
- out_inst  output  32  head instruction
- out_imm_type  output  3  immediate-type select for the head entry
- out_imm_used  output  1  head instruction consumes an immediate
- out_illegal  output  1  head opcode is unsupported
- squash  input  1  X-stage redirect; flush all entries
- occupancy  output  4  number of valid entries (0..DEPTH)
- halted  output  1  block is in HALT

Behaviour:
- Reset (asynchronous, active-high):
  - occupancy=0, head/tail pointers=0, state=RUN.
  - out_val=0, in_rdy=1, halted=0.
  - Storage contents are don't-care. out_inst, out_imm_type, out_imm_used and out_illegal are don't-care while out_val=0.
- Classification, done combinationally on in_inst[6:0] at enqueue; results stored with the entry:
  - 0000011 (load), 0010011 (op-imm), 1100111 (jalr), 1110011 (csr): type 0, used=1
  - 0100011 (store): type 1, used=1
  - 1100011 (branch): type 2, used=1
  - 0110111 (lui), 0010111 (auipc): type 3, used=1
  - 1101111 (jal): type 4, used=1
  - 0110011 (op): type 0, used=0
  - any other opcode: type 0, used=0, illegal=1
- Handshakes:
  - Enqueue fires when in_val && in_rdy.
  - Dequeue fires when out_val && out_rdy.
  - in_rdy = (state==RUN) && (occupancy<DEPTH). There is no combinational path from out_rdy to in_rdy, so a full buffer does not accept in the same cycle as a dequeue.
  - out_val = (state==RUN) && (occupancy!=0).
  - Outputs are driven combinationally from the head entry, so there is zero added latency beyond the single enqueue edge.
- Simultaneous enqueue and dequeue with 0<occupancy<DEPTH: occupancy unchanged, both pointers advance.
- Ordering: strict FIFO; pointers increment modulo DEPTH, wrapping DEPTH-1 -> 0.
- Squash:
  - Takes effect at the next edge: occupancy := 0, head := tail.
  - A simultaneous enqueue is dropped.
  - A simultaneous dequeue still counts as delivered; D has already sampled the entry.
  - Squash has priority over every other update except reset.
- FSM:
  - RUN -> HALT on a dequeue of an entry with out_illegal=1, unless squash is asserted in the same cycle.
  - HALT: out_val=0, in_rdy=0, halted=1. Squash clears entries but stays in HALT. Only reset exits HALT.
  - Non-illegal dequeues never change state.
- Reset mid-operation: all entries are discarded immediately, independent of clk.
- Occupancy never exceeds DEPTH and never underflows. The verifier asserts this every cycle.

Test Plan:
- Classification:
  - Stimulus: enqueue 0x00500093, 0x0020A023, 0x00000063, 0x000010B7, 0x0000006F, 0x002081B3 with out_rdy=1.
  - Response: each appears one cycle after enqueue with out_imm_type 0, 1, 2, 3, 4, 0 and out_imm_used 1, 1, 1, 1, 1, 0, in order.
- Full and wrap:
  - Stimulus: DEPTH=2, out_rdy=0, enqueue A, B.
  - Response: in_rdy=0 and occupancy=2 after the second edge.
  - Stimulus: raise out_rdy for one cycle.
  - Response: A dequeued, in_rdy=1; enqueue C lands at index 0; the next dequeue order is B, then C.
- Simultaneous enqueue and dequeue:
  - Stimulus: occupancy=1, in_val=1, out_rdy=1 in the same cycle.
  - Response: occupancy stays 1, and out_inst shows the new entry next cycle.
- Squash:
  - Stimulus: occupancy=2, squash=1 with in_val=1.
  - Response: next cycle occupancy=0, out_val=0, and the incoming instruction is absent.
- Illegal halt:
  - Stimulus: enqueue 0xFFFFFFFF, then 0x00500093; dequeue the first.
  - Response: out_illegal=1 on the first; next cycle halted=1, out_val=0, in_rdy=0.
  - Stimulus: a squash while in HALT.
  - Response: remains halted.
  - Stimulus: reset.
  - Response: RUN resumes with occupancy=0.
- Asynchronous reset:
  - Stimulus: assert reset between clock edges with occupancy=2.
  - Response: out_val=0 and occupancy=0 before the next rising edge.
